ps2_rx: RTL and testbench
=========================

PS2_RX -- requirements
Module: ps2_rx

Interface
REQ-001 Parameter FILTER_LEN, default 8, number of consecutive clk_sys samples a line must hold a new level before the filtered value changes.
REQ-002 Parameter TIMEOUT_CYC, default 20000, clk_sys cycles without a filtered ps2_clk falling edge before a partial frame is discarded.
REQ-003 Port clk_sys  input  1  system clock; all state is clocked on its rising edge.
REQ-004 Port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 Port ps2_clk  input  1  raw PS/2 clock line, asynchronous to clk_sys.
REQ-006 Port ps2_data  input  1  raw PS/2 data line, asynchronous to clk_sys.
REQ-007 Port ps2_key  output  11  key event: [10] toggles once per event, [9] 1=press/0=release, [8] 1=E0-extended, [7:0] scancode.
REQ-008 Port frame_err  output  1  one-cycle pulse on a parity, start-bit or stop-bit error, or on a timeout.

Function
REQ-009 Both PS/2 inputs SHALL pass through a 2-flop synchroniser, then a FILTER_LEN-sample glitch filter; filtered idle level is 1.
REQ-010 A bit SHALL be sampled from filtered ps2_data on the cycle a filtered ps2_clk 1->0 transition is detected.
REQ-011 Frame format: start 0, 8 data bits LSB first, odd parity, stop 1; 4-bit bit counter 0..10.
REQ-012 FSM states: IDLE, DATA, PARITY, STOP; IDLE->DATA on a sampled 0; a sampled 1 in IDLE is ignored; DATA->PARITY after 8 bits; PARITY->STOP; STOP->IDLE.
REQ-013 Frame valid iff stop=1 and XOR of 8 data bits and parity is 1; otherwise frame_err pulses and the byte is dropped.
REQ-014 Byte E0 SHALL set the ext flag; byte F0 SHALL set the rel flag; neither updates ps2_key.
REQ-015 Byte E1 SHALL load a skip counter with 7; the next 7 valid bytes are discarded without output (Pause sequence).
REQ-016 Any other valid byte SHALL, one cycle after the STOP sample, write ps2_key = {~ps2_key[10], ~rel, ext, byte} and clear ext and rel.
REQ-017 ps2_key[10] SHALL change only on an emitted event; [9:0] hold between events.
REQ-018 Sequence E0 F0 xx SHALL emit [9]=0, [8]=1; F0 E0 xx SHALL emit the same.
REQ-019 A timeout counter SHALL clear on every filtered falling edge; reaching TIMEOUT_CYC outside IDLE SHALL return to IDLE, clear the bit counter, pulse frame_err.
REQ-020 Timeout in IDLE with ext/rel set SHALL clear ext, rel and skip counter without frame_err.
REQ-021 A frame error SHALL clear ext, rel and skip counter.
REQ-022 The block is receive-only; it never drives ps2_clk or ps2_data.

Reset
REQ-023 reset_n low SHALL asynchronously set ps2_key=0, frame_err=0, FSM=IDLE, counters=0, ext=rel=0, filter and synchroniser outputs=1.
REQ-024 Reset asserted mid-frame SHALL discard the partial frame; after release the next start bit begins a fresh frame.

Structure
REQ-025 Shared package ps2_pkg SHALL hold the FSM state enum and constants PS2_EXT=8'hE0, PS2_REL=8'hF0, PS2_PAUSE=8'hE1, PAUSE_SKIP=7.
REQ-026 The synchroniser-plus-filter SHALL be one sub-module, ps2_line_filter, instantiated once per line.

Verification
REQ-027 Frame 0x1C, parity 0, stop 1 -> ps2_key[10] toggles, [9:0] = {1,0,8'h1C}, no frame_err.
REQ-028 Frames F0 then 1C -> exactly one event, [9:0] = {0,0,8'h1C}.
REQ-029 Frames E0 F0 6B -> one event, [9:0] = {0,1,8'h6B}; a following 1C -> {1,0,8'h1C}.
REQ-030 Frame 0x1C with parity 1 -> frame_err one cycle, ps2_key unchanged; next valid 0x1C -> event emitted.
REQ-031 Start plus 4 data bits then line idle TIMEOUT_CYC cycles -> frame_err, FSM IDLE; next 0x29 frame -> {1,0,8'h29}.
REQ-032 3-cycle low glitch on ps2_clk (FILTER_LEN=8) -> no bit sampled; E1 14 77 E1 F0 14 F0 77 -> no events, then 0x1C -> event.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: frame FSM states and
// the special scancode prefixes that modify or suppress key events.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_REL    = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    // Odd parity holds when the eight data bits plus the parity bit contain an odd count of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_rx_if.sv
// PS/2 line inputs and decoded key-event outputs of the receiver.
interface ps2_rx_if;

    logic        ps2_clk;
    logic        ps2_data;
    logic [10:0] ps2_key;
    logic        frame_err;

    modport master (
        output ps2_clk,
        output ps2_data,
        input  ps2_key,
        input  frame_err
    );

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output ps2_key,
        output frame_err
    );

endinterface

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a glitch filter: the output only follows
// the line after it has held a new level for FILTER_LEN consecutive samples.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic line,
    output logic level
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic          sync_p0;
    logic          sync_p1;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            level   <= 1'b1;
            cnt     <= '0;
        end else begin
            sync_p0 <= line;
            sync_p1 <= sync_p0;
            // Any sample matching the current output restarts the run length.
            if (sync_p1 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                level <= sync_p1;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: filters both lines, deframes 11-bit frames on the
// filtered clock's falling edge and turns scancode bytes into key events.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic    clk_sys,
    input  logic    reset_n,
    ps2_rx_if.slave bus
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic          clk_f;
    logic          data_f;
    logic          clk_q;
    logic          fall;

    ps2_state_e    state;
    ps2_state_e    state_nxt;
    logic [3:0]    bit_cnt;
    logic [3:0]    bit_cnt_nxt;
    logic [7:0]    shreg;
    logic [7:0]    shreg_nxt;
    logic          par;
    logic          par_nxt;
    logic          done_nxt;
    logic          ok_nxt;

    logic          done_p0;
    logic          ok_p0;
    logic [7:0]    byte_p0;

    logic [TW-1:0] to_cnt;
    logic          to_hit;

    logic          ext;
    logic          rel;
    logic [2:0]    skip;
    logic [10:0]   key;
    logic          err;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .line    (bus.ps2_clk),
        .level   (clk_f)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .line    (bus.ps2_data),
        .level   (data_f)
    );

    assign fall   = clk_q & ~clk_f;
    // The counter saturates at TIMEOUT_CYC, so each quiet period fires at most once.
    assign to_hit = (to_cnt == TW'(TIMEOUT_CYC - 1)) && !fall;

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        par_nxt     = par;
        done_nxt    = 1'b0;
        ok_nxt      = 1'b0;
        if (to_hit) begin
            state_nxt   = IDLE;
            bit_cnt_nxt = '0;
        end else if (fall) begin
            case (state)
                IDLE: begin
                    if (!data_f) begin
                        state_nxt   = DATA;
                        bit_cnt_nxt = 4'd1;
                    end
                end
                DATA: begin
                    shreg_nxt   = {data_f, shreg[7:1]};
                    bit_cnt_nxt = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd8) begin
                        state_nxt = PARITY;
                    end
                end
                PARITY: begin
                    par_nxt     = data_f;
                    bit_cnt_nxt = 4'd10;
                    state_nxt   = STOP;
                end
                STOP: begin
                    done_nxt    = 1'b1;
                    ok_nxt      = data_f && odd_parity_ok(shreg, par);
                    bit_cnt_nxt = '0;
                    state_nxt   = IDLE;
                end
                default: begin
                    state_nxt   = IDLE;
                    bit_cnt_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            par     <= 1'b0;
            clk_q   <= 1'b1;
            to_cnt  <= '0;
            done_p0 <= 1'b0;
            ok_p0   <= 1'b0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            shreg   <= shreg_nxt;
            par     <= par_nxt;
            clk_q   <= clk_f;
            done_p0 <= done_nxt;
            ok_p0   <= ok_nxt;
            if (fall) begin
                to_cnt <= '0;
            end else if (to_cnt != TW'(TIMEOUT_CYC)) begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    // Stage p0: completed byte, decoded one cycle after the stop bit is sampled.
    always_ff @(posedge clk_sys) begin
        if (done_nxt) begin
            byte_p0 <= shreg;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ext  <= 1'b0;
            rel  <= 1'b0;
            skip <= '0;
            key  <= '0;
            err  <= 1'b0;
        end else begin
            err <= 1'b0;
            if (to_hit) begin
                ext  <= 1'b0;
                rel  <= 1'b0;
                skip <= '0;
                err  <= (state != IDLE);
            end else if (done_p0) begin
                if (!ok_p0) begin
                    ext  <= 1'b0;
                    rel  <= 1'b0;
                    skip <= '0;
                    err  <= 1'b1;
                end else if (skip != '0) begin
                    skip <= skip - 3'd1;
                end else begin
                    case (byte_p0)
                        PS2_EXT:   ext  <= 1'b1;
                        PS2_REL:   rel  <= 1'b1;
                        PS2_PAUSE: skip <= PAUSE_SKIP;
                        default: begin
                            key <= {~key[10], ~rel, ext, byte_p0};
                            ext <= 1'b0;
                            rel <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.ps2_key   = key;
    assign bus.frame_err = err;

endmodule

// File: tb/tb_ps2_rx.sv
// Randomised and directed frame stimulus for ps2_rx, checked against a
// byte-level model of the prefix/release/pause decoding rules.
module tb_ps2_rx;
    import ps2_pkg::*;

    localparam int FILT = 8;
    localparam int TO   = 1500;
    localparam int HALF = 20;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;

    ps2_rx_if bus ();

    ps2_rx #(.FILTER_LEN(FILT), .TIMEOUT_CYC(TO)) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [10:0] m_key;
    bit          m_ext;
    bit          m_rel;
    int          m_skip;
    int          m_err = 0;
    int          m_ev  = 0;

    // Observed event/error activity
    int   ev_cnt   = 0;
    int   err_cnt  = 0;
    int   wide_cnt = 0;
    logic prev10   = 1'b0;
    logic err_prev = 1'b0;

    always @(negedge clk_sys) begin
        if (reset_n) begin
            if (bus.ps2_key[10] != prev10) ev_cnt++;
            if (bus.frame_err) begin
                err_cnt++;
                if (err_prev) wide_cnt++;
            end
        end
        prev10   = bus.ps2_key[10];
        err_prev = bus.frame_err;
    end

    task automatic model_reset();
        m_key  = '0;
        m_ext  = 0;
        m_rel  = 0;
        m_skip = 0;
    endtask

    task automatic model_clear();
        m_ext  = 0;
        m_rel  = 0;
        m_skip = 0;
    endtask

    task automatic model_byte(input logic [7:0] b, input bit ok);
        if (!ok) begin
            m_err++;
            model_clear();
        end else if (m_skip > 0) begin
            m_skip--;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_rel = 1;
        end else if (b == 8'hE1) begin
            m_skip = 7;
        end else begin
            m_key = {~m_key[10], ~m_rel, m_ext, b};
            m_ext = 0;
            m_rel = 0;
            m_ev++;
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk_sys);
    endtask

    task automatic put_bit(input logic b);
        bus.ps2_data = b;
        wait_clk(HALF);
        bus.ps2_clk = 1'b0;
        wait_clk(HALF);
        bus.ps2_clk = 1'b1;
    endtask

    task automatic check_state(input string tag);
        @(negedge clk_sys);
        #1;
        chk({tag, " key"}, 32'(bus.ps2_key), 32'(m_key));
        chk({tag, " errs"}, 32'(err_cnt), 32'(m_err));
        chk({tag, " events"}, 32'(ev_cnt), 32'(m_ev));
    endtask

    task automatic send_frame(input logic [7:0] b, input bit perr, input bit serr);
        logic p;
        p = ~(^b) ^ perr;
        put_bit(1'b0);
        for (int i = 0; i < 8; i++) put_bit(b[i]);
        put_bit(p);
        put_bit(~serr);
        bus.ps2_data = 1'b1;
        wait_clk(HALF);
        model_byte(b, !perr && !serr);
        check_state($sformatf("frame_%02h_p%0d_s%0d", b, perr, serr));
    endtask

    task automatic send_seq(input logic [7:0] seq[$]);
        foreach (seq[i]) send_frame(seq[i], 0, 0);
    endtask

    logic [7:0] b;
    bit         perr;
    bit         serr;

    initial begin
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        model_reset();
        wait_clk(5);
        #1;
        chk("reset key", 32'(bus.ps2_key), 32'h0);
        chk("reset frame_err", 32'(bus.frame_err), 32'h0);
        @(negedge clk_sys);
        reset_n = 1'b1;
        wait_clk(5);

        send_frame(8'h1C, 0, 0);
        send_seq('{8'hF0, 8'h1C});
        send_seq('{8'hE0, 8'hF0, 8'h6B, 8'h1C});
        send_seq('{8'hF0, 8'hE0, 8'h6B});
        send_frame(8'h1C, 1, 0);
        send_frame(8'h1C, 0, 0);
        send_frame(8'h1C, 0, 1);
        send_frame(8'hE0, 0, 0);
        send_frame(8'h5A, 1, 0);
        send_frame(8'h1C, 0, 0);

        // Start bit plus four data bits, then the keyboard goes quiet.
        put_bit(1'b0);
        for (int i = 0; i < 4; i++) put_bit(1'b1);
        bus.ps2_data = 1'b1;
        wait_clk(TO + 50);
        m_err++;
        model_clear();
        check_state("timeout partial");
        send_frame(8'h29, 0, 0);

        // Pending prefix expires on an idle timeout without an error.
        send_seq('{8'hE0, 8'hF0});
        wait_clk(TO + 50);
        model_clear();
        check_state("idle timeout");
        send_frame(8'h1C, 0, 0);

        // Short low glitch on the clock while data is low must not start a frame.
        bus.ps2_data = 1'b0;
        wait_clk(2);
        bus.ps2_clk = 1'b0;
        wait_clk(3);
        bus.ps2_clk = 1'b1;
        wait_clk(2);
        bus.ps2_data = 1'b1;
        wait_clk(40);
        check_state("glitch");
        send_seq('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h1C});

        // Reset in the middle of a frame.
        send_frame(8'hE0, 0, 0);
        put_bit(1'b0);
        put_bit(1'b1);
        put_bit(1'b0);
        #3;
        reset_n = 1'b0;
        bus.ps2_data = 1'b1;
        wait_clk(3);
        #1;
        chk("midreset key", 32'(bus.ps2_key), 32'h0);
        chk("midreset frame_err", 32'(bus.frame_err), 32'h0);
        model_reset();
        @(negedge clk_sys);
        reset_n = 1'b1;
        wait_clk(10);
        send_frame(8'h1C, 0, 0);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 7))
                0:       b = PS2_EXT;
                1:       b = PS2_REL;
                2:       b = (($urandom_range(0, 3) == 0) ? PS2_PAUSE : PS2_REL);
                default: b = 8'($urandom_range(0, 255));
            endcase
            perr = ($urandom_range(0, 9) == 0);
            serr = !perr && ($urandom_range(0, 14) == 0);
            send_frame(b, perr, serr);
        end

        chk("single-cycle frame_err", 32'(wide_cnt), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
